// File: rtl/toggle_pulse_gen_if.sv
// Button-side bundle: raw button in; toggle pulse, debounced level and pulse count out.
// No handshake; outputs are registered and valid every cycle after reset.
interface toggle_pulse_gen_if #(
  parameter int CNT_W = 8
);
  logic             btn;
  logic             t;
  logic             lvl;
  logic [CNT_W-1:0] pulse_cnt;

  modport master (output btn, input t, lvl, pulse_cnt);
  modport slave  (input btn, output t, lvl, pulse_cnt);
endinterface

// File: rtl/toggle_pulse_gen.sv
// Debounced push-button to single-cycle toggle pulse, with wrapping pulse counter.
// Latency: edge sampled at E0 gives lvl/t after edge E0+2+DEBOUNCE_CYCLES; no backpressure.
module toggle_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int EDGE_SEL        = 0,
  parameter int CNT_W           = 8
) (
  input  logic                c,
  input  logic                rst,
  toggle_pulse_gen_if.slave   bus
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ARM, DOWN, DISARM} state_t;

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  state_t           state_q, state_d;
  logic [DW-1:0]    dcnt_q, dcnt_d;
  logic             t_q, t_d;
  logic             lvl_q, lvl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_ev, rel_ev, fire;

  always_comb begin
    s1_d     = bus.btn;
    s2_d     = s1_q;
    state_d  = state_q;
    dcnt_d   = dcnt_q;
    press_ev = 1'b0;
    rel_ev   = 1'b0;
    // A bounce in ARM/DISARM falls back to the previous stable state.
    case (state_q)
      IDLE: begin
        if (s2_q) begin
          state_d = ARM;
          dcnt_d  = '0;
        end
      end
      ARM: begin
        if (!s2_q) begin
          state_d = IDLE;
        end else if (dcnt_q == D_LAST) begin
          state_d  = DOWN;
          press_ev = 1'b1;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      DOWN: begin
        if (!s2_q) begin
          state_d = DISARM;
          dcnt_d  = '0;
        end
      end
      DISARM: begin
        if (s2_q) begin
          state_d = DOWN;
        end else if (dcnt_q == D_LAST) begin
          state_d = IDLE;
          rel_ev  = 1'b1;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (EDGE_SEL == 0)      fire = press_ev;
    else if (EDGE_SEL == 1) fire = rel_ev;
    else                    fire = press_ev | rel_ev;

    t_d   = fire;
    cnt_d = fire ? (cnt_q + CNT_W'(1)) : cnt_q;
    lvl_d = (state_d == DOWN) || (state_d == DISARM);
  end

  always_ff @(posedge c) begin
    if (!rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= IDLE;
      dcnt_q  <= '0;
      t_q     <= 1'b0;
      lvl_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      t_q     <= t_d;
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.t         = t_q;
  assign bus.lvl       = lvl_q;
  assign bus.pulse_cnt = cnt_q;

endmodule

// File: tb/tb_toggle_pulse_gen.sv
// Five parameterisations share one button/reset; a streak-count model checks all every cycle.
module tb_toggle_pulse_gen;

  localparam int N = 5;
  localparam int DP[N] = '{4, 4, 4, 4, 1};
  localparam int SP[N] = '{0, 1, 2, 0, 2};
  localparam int WP[N] = '{8, 8, 8, 2, 8};

  logic c = 1'b0;
  logic rst = 1'b0;
  logic btn = 1'b0;
  logic       dut_t   [N];
  logic       dut_lvl [N];
  logic [7:0] dut_cnt [N];
  logic       q;

  int total = 0;
  int bad = 0;
  bit armed = 0;

  always #5 c = ~c;

  for (genvar g = 0; g < N; g++) begin : g_dut
    toggle_pulse_gen_if #(.CNT_W(WP[g])) bus ();
    assign bus.btn = btn;
    toggle_pulse_gen #(
      .DEBOUNCE_CYCLES(DP[g]),
      .EDGE_SEL(SP[g]),
      .CNT_W(WP[g])
    ) u_dut (
      .c(c),
      .rst(rst),
      .bus(bus)
    );
    assign dut_t[g]   = bus.t;
    assign dut_lvl[g] = bus.lvl;
    assign dut_cnt[g] = 8'(bus.pulse_cnt);
  end

  // T flip-flop fed by the both-edges instance.
  always @(posedge c) begin
    if (!rst)          q <= 1'b0;
    else if (dut_t[2]) q <= ~q;
  end

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: a level is accepted once the synchronized input has disagreed with
  // the current level for DEBOUNCE_CYCLES+1 consecutive edges.
  bit m_s1, m_s2;
  bit m_lvl [N];
  int m_run [N];
  bit m_t   [N];
  int m_cnt [N];

  always @(posedge c) begin
    armed = 1;
    if (!rst) begin
      m_s1 = 0;
      m_s2 = 0;
      for (int i = 0; i < N; i++) begin
        m_lvl[i] = 0; m_run[i] = 0; m_t[i] = 0; m_cnt[i] = 0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        bit pr, rl;
        pr = 0; rl = 0;
        if (m_s2 != m_lvl[i]) m_run[i]++;
        else                  m_run[i] = 0;
        if (m_run[i] == DP[i] + 1) begin
          m_lvl[i] = ~m_lvl[i];
          m_run[i] = 0;
          if (m_lvl[i]) pr = 1; else rl = 1;
        end
        m_t[i] = (SP[i] == 2) ? (pr | rl) : (SP[i] == 0) ? pr : rl;
        if (m_t[i]) m_cnt[i] = (m_cnt[i] + 1) % (1 << WP[i]);
      end
      m_s2 = m_s1;
      m_s1 = btn;
    end
  end

  always @(negedge c) begin
    if (armed) begin
      for (int i = 0; i < N; i++) begin
        chk($sformatf("model_t[%0d]", i), int'(dut_t[i]), int'(m_t[i]));
        chk($sformatf("model_lvl[%0d]", i), int'(dut_lvl[i]), int'(m_lvl[i]));
        chk($sformatf("model_cnt[%0d]", i), int'(dut_cnt[i]), m_cnt[i]);
      end
    end
  end

  task automatic tick();
    @(posedge c);
    #1;
  endtask

  int wrap_exp[5] = '{1, 2, 3, 0, 1};

  initial begin
    tick();
    tick();
    chk("reset_t", int'(dut_t[0]), 0);
    chk("reset_lvl", int'(dut_lvl[0]), 0);
    chk("reset_cnt", int'(dut_cnt[0]), 0);
    rst = 1'b1;
    repeat (3) tick();

    // Clean press held 20 cycles, then release.
    btn = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 4) chk("d1_press_t", int'(dut_t[4]), 1);
      if (i == 6) begin
        chk("press_t_early", int'(dut_t[0]), 0);
        chk("press_lvl_early", int'(dut_lvl[0]), 0);
      end
      if (i == 7) begin
        chk("press_t", int'(dut_t[0]), 1);
        chk("press_lvl", int'(dut_lvl[0]), 1);
        chk("press_cnt", int'(dut_cnt[0]), 1);
        chk("relmode_no_press_t", int'(dut_t[1]), 0);
      end
      if (i == 8) begin
        chk("press_t_width", int'(dut_t[0]), 0);
        chk("tff_q_after_press", int'(q), 1);
      end
    end
    btn = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 6) begin
        chk("rel_t_early", int'(dut_t[1]), 0);
        chk("rel_lvl_early", int'(dut_lvl[0]), 1);
      end
      if (i == 7) begin
        chk("rel_t", int'(dut_t[1]), 1);
        chk("rel_lvl", int'(dut_lvl[1]), 0);
        chk("both_cnt", int'(dut_cnt[2]), 2);
      end
      if (i == 9) begin
        chk("tff_q_after_release", int'(q), 0);
        chk("press_mode_cnt_hold", int'(dut_cnt[0]), 1);
      end
    end

    // Bounce: high 3, low 1, then steady high.
    btn = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("bounce_no_t", int'(dut_t[0]), 0);
    end
    btn = 1'b0;
    tick();
    chk("bounce_no_t", int'(dut_t[0]), 0);
    btn = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk($sformatf("bounce_t_%0d", i), int'(dut_t[0]), (i == 7) ? 1 : 0);
    end
    chk("bounce_cnt", int'(dut_cnt[0]), 2);
    btn = 1'b0;
    repeat (12) tick();

    // Reset during ARM with the button held.
    btn = 1'b1;
    repeat (4) tick();
    rst = 1'b0;
    tick();
    chk("midrst_t", int'(dut_t[0]), 0);
    chk("midrst_lvl", int'(dut_lvl[0]), 0);
    chk("midrst_cnt", int'(dut_cnt[0]), 0);
    chk("midrst_d1_lvl", int'(dut_lvl[4]), 0);
    rst = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk($sformatf("post_rst_t_%0d", i), int'(dut_t[0]), (i == 7) ? 1 : 0);
    end
    chk("post_rst_cnt", int'(dut_cnt[0]), 1);
    btn = 1'b0;
    repeat (12) tick();

    // Counter wrap on the 2-bit instance.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    for (int p = 0; p < 5; p++) begin
      btn = 1'b1;
      for (int i = 1; i <= 10; i++) begin
        tick();
        if (i == 6) chk("wrap_t_early", int'(dut_t[3]), 0);
        if (i == 7) begin
          chk("wrap_t", int'(dut_t[3]), 1);
          chk($sformatf("wrap_cnt_%0d", p), int'(dut_cnt[3]), wrap_exp[p]);
        end
        if (i == 8) chk("wrap_t_width", int'(dut_t[3]), 0);
      end
      btn = 1'b0;
      repeat (10) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
